// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Stall/bubble/flush sequencing for load-use hazards, EX redirects
//            and multi-cycle data-memory waits, with saturating counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_controller #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic             id_ex_reg_wr_sig_i,
    input  logic [4:0]       id_ex_reg_wr_addr_i,
    input  logic [1:0]       id_ex_data_dest_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             id_ex_stall_o,
    output logic             ex_mem_stall_o,
    output logic             id_ex_bubble_o,
    output logic             mem_wb_bubble_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    // Write-back source codes: ALU = 2'b00, MEM = 2'b01, PC = 2'b10.
    localparam logic [1:0]          c_DEST_MEM = 2'b01;
    localparam int unsigned         c_WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic w_wait;
    logic w_redirect;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_load_use;

    assign w_wait     = mem_req_i && !mem_ready_i;
    assign w_redirect = !w_wait && ex_branch_taken_i;
    assign w_rs1_hit  = id_rs1_used_i && (id_rs1_addr_i == id_ex_reg_wr_addr_i);
    assign w_rs2_hit  = id_rs2_used_i && (id_rs2_addr_i == id_ex_reg_wr_addr_i);

    // A redirect squashes the ID instruction, so its hazard is irrelevant.
    assign w_load_use = !w_wait && !ex_branch_taken_i && id_ex_reg_wr_sig_i
                        && (id_ex_data_dest_i == c_DEST_MEM)
                        && (id_ex_reg_wr_addr_i != 5'd0)
                        && (w_rs1_hit || w_rs2_hit);

    assign pc_stall_o      = rst_n_i && (w_wait || w_load_use);
    assign if_id_stall_o   = rst_n_i && (w_wait || w_load_use);
    assign id_ex_stall_o   = rst_n_i && w_wait;
    assign ex_mem_stall_o  = rst_n_i && w_wait;
    assign id_ex_bubble_o  = rst_n_i && w_load_use;
    assign mem_wb_bubble_o = rst_n_i && w_wait;
    assign if_id_flush_o   = rst_n_i && w_redirect;
    assign id_ex_flush_o   = rst_n_i && w_redirect;

    assign mem_timeout_o = r_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_wait) begin
                        r_state <= ST_MEM_WAIT;
                    end
                end
                ST_MEM_WAIT: begin
                    if (!w_wait) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= '0;
                    end else begin
                        // Counter parks at the limit; the flag keeps the history.
                        if (r_wait_cnt != c_WAIT_MAX) begin
                            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        end
                        if (r_wait_cnt >= c_WAIT_MAX - c_WAIT_W'(1)) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase

            if (pc_stall_o && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != {CNT_W{1'b1}})) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
